// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types and constants for the register-file write-back front end.
// The entry struct matches the default widths; other widths use a local struct.
package rf_wb_arbiter_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_ADDR_W = 5;
    localparam int REG_ZERO  = 0;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// Dual-push, single-pop circular buffer of write-back entries.
// Entries are presented in age order: index 0 is the head (oldest).
module rf_wb_fifo
    import rf_wb_arbiter_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = wb_entry_t,
    localparam int CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push0,
    input  entry_t           push0_entry,
    input  logic             push1,
    input  entry_t           push1_entry,
    input  logic             pop,
    output logic [CNT_W-1:0] count,
    output entry_t           entries [DEPTH],
    output logic [DEPTH-1:0] valids
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr_nx;
    logic [1:0]       n_push;
    entry_t           mem [DEPTH];

    assign n_push    = {1'b0, push0} + {1'b0, push1};
    assign wr_ptr_nx = wr_ptr + PTR_W'(1);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(n_push);
            rd_ptr <= rd_ptr + PTR_W'(pop);
            count  <= count + CNT_W'(n_push) - CNT_W'(pop);
        end
    end

    // NOTE: storage has no reset; the valid bits derived from count make stale contents invisible.
    always_ff @(posedge clk) begin
        if (push0) mem[wr_ptr] <= push0_entry;
        if (push1) mem[push0 ? wr_ptr_nx : wr_ptr] <= push1_entry;
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_age
        assign entries[i] = mem[rd_ptr + PTR_W'(i)];
        assign valids[i]  = (CNT_W'(i) < count);
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Merges MEM and ALU write-backs into the register file's single write port,
// filtering r0 writes and offering a youngest-first bypass of pending writes.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int  DATA_W = WB_DATA_W,
    parameter int  ADDR_W = WB_ADDR_W,
    parameter int  DEPTH  = 4,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    output logic              rf_wen,
    output logic [ADDR_W-1:0] rf_addr_w,
    output logic [DATA_W-1:0] rf_data_w,
    input  logic [ADDR_W-1:0] byp_addr_r1,
    input  logic [ADDR_W-1:0] byp_addr_r2,
    output logic              byp_hit_r1,
    output logic              byp_hit_r2,
    output logic [DATA_W-1:0] byp_data_r1,
    output logic [DATA_W-1:0] byp_data_r2,
    output logic [CNT_W-1:0]  pending_cnt
);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

    logic             need_m;
    logic             need_a;
    logic [CNT_W-1:0] free;
    entry_t           entries [DEPTH];
    logic [DEPTH-1:0] valids;

    assign need_m = mem_valid && (mem_addr != ZERO_ADDR);
    assign need_a = alu_valid && (alu_addr != ZERO_ADDR);

    // The pop of this cycle is deliberately not credited, keeping readies off the pop path.
    assign free      = CNT_W'(DEPTH) - pending_cnt;
    assign mem_ready = (free >= CNT_W'(1)) || (mem_addr == ZERO_ADDR);
    assign alu_ready = (free >= CNT_W'(1) + CNT_W'(need_m)) || (alu_addr == ZERO_ADDR);

    rf_wb_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push0       (need_m && mem_ready),
        .push0_entry ({mem_addr, mem_data}),
        .push1       (need_a && alu_ready),
        .push1_entry ({alu_addr, alu_data}),
        .pop         (rf_wen),
        .count       (pending_cnt),
        .entries     (entries),
        .valids      (valids)
    );

    assign rf_wen    = (pending_cnt != '0);
    assign rf_addr_w = rf_wen ? entries[0].addr : '0;
    assign rf_data_w = rf_wen ? entries[0].data : '0;

    // Oldest-to-youngest scan so the youngest match is the one left standing.
    // NOTE: every output gets a default before the loop, otherwise a latch is inferred.
    always_comb begin
        byp_hit_r1  = 1'b0;
        byp_data_r1 = '0;
        byp_hit_r2  = 1'b0;
        byp_data_r2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valids[i] && byp_addr_r1 != ZERO_ADDR && entries[i].addr == byp_addr_r1) begin
                byp_hit_r1  = 1'b1;
                byp_data_r1 = entries[i].data;
            end
            if (valids[i] && byp_addr_r2 != ZERO_ADDR && entries[i].addr == byp_addr_r2) begin
                byp_hit_r2  = 1'b1;
                byp_data_r2 = entries[i].data;
            end
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios plus randomized traffic
// scored against a queue model of pending writes.
module tb_rf_wb_arbiter;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          mem_valid = 1'b0;
    logic          mem_ready;
    logic [AW-1:0] mem_addr = '0;
    logic [DW-1:0] mem_data = '0;
    logic          alu_valid = 1'b0;
    logic          alu_ready;
    logic [AW-1:0] alu_addr = '0;
    logic [DW-1:0] alu_data = '0;
    logic          rf_wen;
    logic [AW-1:0] rf_addr_w;
    logic [DW-1:0] rf_data_w;
    logic [AW-1:0] byp_addr_r1 = '0;
    logic [AW-1:0] byp_addr_r2 = '0;
    logic          byp_hit_r1;
    logic          byp_hit_r2;
    logic [DW-1:0] byp_data_r1;
    logic [DW-1:0] byp_data_r2;
    logic [CW-1:0] pending_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    // Pending writes, oldest at index 0.
    wr_t q[$];

    rf_wb_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_addr    (alu_addr),
        .alu_data    (alu_data),
        .rf_wen      (rf_wen),
        .rf_addr_w   (rf_addr_w),
        .rf_data_w   (rf_data_w),
        .byp_addr_r1 (byp_addr_r1),
        .byp_addr_r2 (byp_addr_r2),
        .byp_hit_r1  (byp_hit_r1),
        .byp_hit_r2  (byp_hit_r2),
        .byp_data_r1 (byp_data_r1),
        .byp_data_r2 (byp_data_r2),
        .pending_cnt (pending_cnt)
    );

    always #5 clk = ~clk;

    function automatic void ref_byp(input logic [AW-1:0] a, output logic hit, output logic [DW-1:0] d);
        hit = 1'b0;
        d   = '0;
        if (a != '0) begin
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].addr == a) begin
                    hit = 1'b1;
                    d   = q[i].data;
                    break;
                end
            end
        end
    endfunction

    // Called just after a falling edge: drive, compare against the model, take one rising edge.
    task automatic step(input string tag,
                        input logic mv, input logic [AW-1:0] ma, input logic [DW-1:0] md,
                        input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                        input logic [AW-1:0] b1, input logic [AW-1:0] b2,
                        output bit acc_m, output bit acc_a);
        int               free;
        bit               need_m;
        logic [1:0]       exp_rdy;
        logic [AW+DW:0]   exp_wr;
        logic             h1, h2;
        logic [DW-1:0]    d1, d2;
        wr_t              e;
        mem_valid = mv; mem_addr = ma; mem_data = md;
        alu_valid = av; alu_addr = aa; alu_data = ad;
        byp_addr_r1 = b1; byp_addr_r2 = b2;
        #1;
        free       = DEPTH - q.size();
        need_m     = mv && (ma != '0);
        exp_rdy[1] = (free >= 1) || (ma == '0);
        exp_rdy[0] = (free >= 1 + int'(need_m)) || (aa == '0);
        exp_wr     = (q.size() != 0) ? {1'b1, q[0].addr, q[0].data} : '0;
        ref_byp(b1, h1, d1);
        ref_byp(b2, h2, d2);

        checks++;
        if ({mem_ready, alu_ready} !== exp_rdy) begin
            errors++;
            $display("FAIL %s readies got %b want %b", tag, {mem_ready, alu_ready}, exp_rdy);
        end
        checks++;
        if ({rf_wen, rf_addr_w, rf_data_w} !== exp_wr) begin
            errors++;
            $display("FAIL %s write port got %0h want %0h", tag, {rf_wen, rf_addr_w, rf_data_w}, exp_wr);
        end
        checks++;
        if (pending_cnt !== CW'(q.size())) begin
            errors++;
            $display("FAIL %s pending_cnt got %0d want %0d", tag, pending_cnt, q.size());
        end
        checks++;
        if ({byp_hit_r1, byp_data_r1} !== {h1, d1}) begin
            errors++;
            $display("FAIL %s byp_r1 addr %0d got %b/%0h want %b/%0h", tag, b1, byp_hit_r1, byp_data_r1, h1, d1);
        end
        checks++;
        if ({byp_hit_r2, byp_data_r2} !== {h2, d2}) begin
            errors++;
            $display("FAIL %s byp_r2 addr %0d got %b/%0h want %b/%0h", tag, b2, byp_hit_r2, byp_data_r2, h2, d2);
        end

        acc_m = mv && exp_rdy[1];
        acc_a = av && exp_rdy[0];
        @(posedge clk);
        if (q.size() != 0) void'(q.pop_front());
        if (acc_m && ma != '0) begin
            e.addr = ma; e.data = md; q.push_back(e);
        end
        if (acc_a && aa != '0) begin
            e.addr = aa; e.data = ad; q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic idle(input string tag, input int n, input logic [AW-1:0] b1);
        bit am, aa;
        for (int i = 0; i < n; i++) step(tag, 0, '0, '0, 0, '0, '0, b1, '0, am, aa);
    endtask

    task automatic test_reset();
        byp_addr_r1 = 5'd3;
        byp_addr_r2 = 5'd7;
        #2;
        checks++;
        if ({rf_wen, rf_addr_w, rf_data_w, pending_cnt} !== '0) begin
            errors++;
            $display("FAIL reset write port/count got %0h want 0", {rf_wen, rf_addr_w, rf_data_w, pending_cnt});
        end
        checks++;
        if ({byp_hit_r1, byp_data_r1, byp_hit_r2, byp_data_r2} !== '0) begin
            errors++;
            $display("FAIL reset bypass got %0h want 0", {byp_hit_r1, byp_data_r1, byp_hit_r2, byp_data_r2});
        end
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({mem_ready, alu_ready} !== 2'b11) begin
            errors++;
            $display("FAIL reset readies got %b want 11", {mem_ready, alu_ready});
        end
    endtask

    task automatic test_single_alu();
        bit am, aa;
        step("single", 0, '0, '0, 1, 5'd5, 32'h1234, 5'd5, '0, am, aa);
        checks++;
        if ({rf_wen, rf_addr_w, rf_data_w} !== {1'b1, 5'd5, 32'h1234}) begin
            errors++;
            $display("FAIL single write got %b/%0d/%0h want 1/5/1234", rf_wen, rf_addr_w, rf_data_w);
        end
        idle("single_drain", 1, 5'd5);
        checks++;
        if ({rf_wen, pending_cnt} !== {1'b0, CW'(0)}) begin
            errors++;
            $display("FAIL single after got wen %b cnt %0d want 0 0", rf_wen, pending_cnt);
        end
    endtask

    task automatic test_same_reg();
        bit am, aa;
        step("same_reg", 1, 5'd7, 32'hAAAA, 1, 5'd7, 32'hBBBB, 5'd7, 5'd7, am, aa);
        checks++;
        if ({rf_wen, rf_data_w, byp_hit_r1, byp_data_r1, pending_cnt} !== {1'b1, 32'hAAAA, 1'b1, 32'hBBBB, CW'(2)}) begin
            errors++;
            $display("FAIL same_reg first got wen %b data %0h hit %b byp %0h cnt %0d", rf_wen, rf_data_w, byp_hit_r1, byp_data_r1, pending_cnt);
        end
        idle("same_reg_drain", 1, 5'd7);
        checks++;
        if ({rf_wen, rf_addr_w, rf_data_w, byp_data_r1} !== {1'b1, 5'd7, 32'hBBBB, 32'hBBBB}) begin
            errors++;
            $display("FAIL same_reg second got wen %b addr %0d data %0h byp %0h", rf_wen, rf_addr_w, rf_data_w, byp_data_r1);
        end
        idle("same_reg_drain", 2, 5'd7);
    endtask

    task automatic test_reg_zero();
        bit am, aa;
        step("reg_zero", 0, '0, '0, 1, 5'd0, 32'hFFFF, 5'd0, '0, am, aa);
        checks++;
        if ({alu_ready, rf_wen, pending_cnt, byp_hit_r1} !== {1'b1, 1'b0, CW'(0), 1'b0}) begin
            errors++;
            $display("FAIL reg_zero got ready %b wen %b cnt %0d hit %b want 1 0 0 0", alu_ready, rf_wen, pending_cnt, byp_hit_r1);
        end
        idle("reg_zero_after", 2, 5'd0);
    endtask

    task automatic test_backpressure();
        bit am, aa;
        step("bp", 1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 5'd2, 5'd1, am, aa);
        step("bp", 1, 5'd3, 32'h33, 1, 5'd4, 32'h44, 5'd4, 5'd3, am, aa);
        step("bp", 1, 5'd5, 32'h55, 1, 5'd6, 32'h66, 5'd6, 5'd5, am, aa);
        checks++;
        if ({am, aa} !== 2'b10) begin
            errors++;
            $display("FAIL bp accept got m%b a%b want m1 a0", am, aa);
        end
        checks++;
        if ({mem_ready, alu_ready, pending_cnt} !== {2'b10, CW'(3)}) begin
            errors++;
            $display("FAIL bp held readies %b cnt %0d want 10 3", {mem_ready, alu_ready}, pending_cnt);
        end
        mem_addr = 5'd0;
        #1;
        checks++;
        if ({mem_ready, alu_ready} !== 2'b11) begin
            errors++;
            $display("FAIL bp r0 readies got %b want 11", {mem_ready, alu_ready});
        end
        step("bp_retry", 0, '0, '0, 1, 5'd6, 32'h66, 5'd6, 5'd5, am, aa);
        idle("bp_drain", 5, 5'd6);
    endtask

    task automatic test_reset_mid_drain();
        bit am, aa;
        step("rst_fill", 1, 5'd8, 32'h88, 1, 5'd9, 32'h99, 5'd9, 5'd8, am, aa);
        step("rst_fill", 1, 5'd10, 32'hA0, 1, 5'd11, 32'hB0, 5'd9, 5'd11, am, aa);
        mem_valid = 1'b0;
        alu_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({rf_wen, pending_cnt, byp_hit_r1, byp_hit_r2} !== {1'b0, CW'(0), 2'b00}) begin
            errors++;
            $display("FAIL rst_mid got wen %b cnt %0d hits %b%b want 0 0 00", rf_wen, pending_cnt, byp_hit_r1, byp_hit_r2);
        end
        q.delete();
        #1 rst_n = 1'b1;
        @(negedge clk);
        idle("rst_after", 3, 5'd11);
    endtask

    task automatic test_random();
        bit            am = 1'b0, aa = 1'b0;
        logic          mv = 1'b0, av = 1'b0;
        logic [AW-1:0] ma = '0, a_addr = '0;
        logic [DW-1:0] md = '0, a_data = '0;
        for (int c = 0; c < 400; c++) begin
            if (!mv || am) begin
                mv = ($urandom_range(0, 9) < 7);
                ma = AW'($urandom_range(0, 7));
                md = $urandom;
            end
            if (!av || aa) begin
                av     = ($urandom_range(0, 9) < 7);
                a_addr = AW'($urandom_range(0, 7));
                a_data = $urandom;
            end
            step("random", mv, ma, md, av, a_addr, a_data,
                 AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), am, aa);
        end
        idle("random_drain", 5, 5'd1);
    endtask

    initial begin
        test_reset();
        test_single_alu();
        test_same_reg();
        test_reg_zero();
        test_backpressure();
        test_reset_mid_drain();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
